// File: rtl/level_sequencer.sv
// Game-flow controller: sequences start, play, death and level transitions.
// Optional life tracking and the OVER state are built when LEVEL_SEQUENCER_LIVES_EN is defined.
module level_sequencer #(
  parameter int NUM_LEVELS   = 2,
  parameter int DEATH_FRAMES = 30,
  parameter int XFER_FRAMES  = 60,
  parameter int LIVES        = 5
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       hit,
  input  logic       at_goal,
  input  logic       collected_all,
  output logic       initialize_level,
  output logic       new_level,
  output logic       dead,
  output logic       freeze,
  output logic [3:0] level,
  output logic [2:0] state_out,
  output logic       game_won,
  output logic [3:0] lives_left
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_DYING = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_WON   = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] XFER_LAST  = 8'(XFER_FRAMES - 1);
  localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
`ifdef LEVEL_SEQUENCER_LIVES_EN
  localparam logic [3:0] LIVES_LOAD = 4'(LIVES);
`else
  // Lives are not tracked in this build, so the load value collapses to zero.
  localparam logic [3:0] LIVES_LOAD = 4'(LIVES) & 4'h0;
`endif

  logic [2:0] state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic [3:0] level_next;
  logic [3:0] lives_next;
  logic       start_q;
  logic       start_evt;
  logic       init_next, new_next, dead_next;

  assign start_evt = start & ~start_q;
  assign state_out = state_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    level_next = level;
    lives_next = lives_left;
    init_next  = 1'b0;
    new_next   = 1'b0;
    dead_next  = 1'b0;

    case (state_reg)
      S_IDLE, S_WON, S_OVER: begin
        if (start_evt) begin
          state_next = S_PLAY;
          level_next = 4'd0;
          lives_next = LIVES_LOAD;
          init_next  = 1'b1;
        end
      end
      S_PLAY: begin
        // A collision outranks reaching the goal in the same frame.
        if (hit) begin
          dead_next  = 1'b1;
`ifdef LEVEL_SEQUENCER_LIVES_EN
          if (lives_left == 4'd1) begin
            state_next = S_OVER;
            lives_next = 4'd0;
          end else begin
            state_next = S_DYING;
            lives_next = lives_left - 4'd1;
          end
`else
          state_next = S_DYING;
`endif
        end else if (at_goal && collected_all) begin
          state_next = S_CLEAR;
        end
      end
      S_DYING: begin
        if (count_reg == DEATH_LAST) begin
          state_next = S_PLAY;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      S_CLEAR: begin
        if (count_reg == XFER_LAST) begin
          if (level == LAST_LEVEL) begin
            state_next = S_WON;
          end else begin
            state_next = S_PLAY;
            level_next = level + 4'd1;
            new_next   = 1'b1;
          end
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Every state is entered with a fresh frame count.
    if (state_next != state_reg) begin
      count_next = 8'd0;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg        <= S_IDLE;
      count_reg        <= 8'd0;
      start_q          <= 1'b0;
      level            <= 4'd0;
      lives_left       <= 4'd0;
      initialize_level <= 1'b0;
      new_level        <= 1'b0;
      dead             <= 1'b0;
      freeze           <= 1'b1;
      game_won         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      start_q          <= start;
      level            <= level_next;
      lives_left       <= lives_next;
      initialize_level <= init_next;
      new_level        <= new_next;
      dead             <= dead_next;
      freeze           <= (state_next != S_PLAY);
      game_won         <= (state_next == S_WON);
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: each step queues the expected output word, then checks it after the clock edge.
// Define LEVEL_SEQUENCER_LIVES_EN to also exercise the lives/OVER path.
module tb_level_sequencer;

  logic       frame_clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       at_goal = 1'b0;
  logic       collected_all = 1'b0;
  logic       initialize_level, new_level, dead, freeze, game_won;
  logic [3:0] level, lives_left;
  logic [2:0] state_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;
  exp_t exp_q[$];

  level_sequencer #(
    .NUM_LEVELS(2),
    .DEATH_FRAMES(30),
    .XFER_FRAMES(60),
    .LIVES(2)
  ) dut (
    .frame_clk(frame_clk),
    .Reset_n(Reset_n),
    .start(start),
    .hit(hit),
    .at_goal(at_goal),
    .collected_all(collected_all),
    .initialize_level(initialize_level),
    .new_level(new_level),
    .dead(dead),
    .freeze(freeze),
    .level(level),
    .state_out(state_out),
    .game_won(game_won),
    .lives_left(lives_left)
  );

  always #5 frame_clk = ~frame_clk;

  // Word layout: state, level, init, new_level, dead, freeze, game_won, lives.
  function automatic logic [15:0] ev(input int st, input int lv, input bit i, input bit n,
                                     input bit d, input bit f, input bit w, input int l);
    return {3'(st), 4'(lv), i, n, d, f, w, 4'(l)};
  endfunction

  function automatic int lv(input int x);
`ifdef LEVEL_SEQUENCER_LIVES_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  function automatic logic [15:0] observed();
    return {state_out, level, initialize_level, new_level, dead, freeze, game_won, lives_left};
  endfunction

  task automatic check_front();
    exp_t e;
    logic [15:0] o;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h required=entry", observed());
    end else begin
      e = exp_q.pop_front();
      o = observed();
      assert (o === e.v) else begin
        failures++;
        $error("FAIL %s observed=%h required=%h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic step(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
    @(posedge frame_clk);
    #1;
    check_front();
  endtask

  task automatic expect_now(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
    check_front();
  endtask

  initial begin
    // Power-on reset
    #12;
    expect_now("reset_hold", ev(0, 0, 0, 0, 0, 1, 0, 0));
    @(posedge frame_clk);
    #1;
    Reset_n = 1'b1;
    step("idle", ev(0, 0, 0, 0, 0, 1, 0, 0));

    // Held start gives one initialize_level pulse
    start = 1'b1;
    step("start", ev(1, 0, 1, 0, 0, 0, 0, lv(2)));
    repeat (4) step("start_held", ev(1, 0, 0, 0, 0, 0, 0, lv(2)));
    start = 1'b0;

    // Hit and goal in the same cycle: death wins; hit ignored while dying
    hit = 1'b1; at_goal = 1'b1; collected_all = 1'b1;
    step("hit_and_goal", ev(2, 0, 0, 0, 1, 1, 0, lv(1)));
    at_goal = 1'b0; collected_all = 1'b0;
    repeat (28) step("dying", ev(2, 0, 0, 0, 0, 1, 0, lv(1)));
    hit = 1'b0;
    step("dying_last", ev(2, 0, 0, 0, 0, 1, 0, lv(1)));
    step("dying_exit", ev(1, 0, 0, 0, 0, 0, 0, lv(1)));

    // Goal without all coins does nothing
    at_goal = 1'b1;
    repeat (100) step("goal_no_coins", ev(1, 0, 0, 0, 0, 0, 0, lv(1)));

    // Clear level 0 -> level 1
    collected_all = 1'b1;
    step("clear0_enter", ev(3, 0, 0, 0, 0, 1, 0, lv(1)));
    at_goal = 1'b0; collected_all = 1'b0;
    repeat (58) step("clear0", ev(3, 0, 0, 0, 0, 1, 0, lv(1)));
    step("clear0_last", ev(3, 0, 0, 0, 0, 1, 0, lv(1)));
    step("new_level", ev(1, 1, 0, 1, 0, 0, 0, lv(1)));

    // Clear last level -> WON
    at_goal = 1'b1; collected_all = 1'b1;
    step("clear1_enter", ev(3, 1, 0, 0, 0, 1, 0, lv(1)));
    at_goal = 1'b0; collected_all = 1'b0;
    repeat (58) step("clear1", ev(3, 1, 0, 0, 0, 1, 0, lv(1)));
    step("clear1_last", ev(3, 1, 0, 0, 0, 1, 0, lv(1)));
    step("won", ev(4, 1, 0, 0, 0, 1, 1, lv(1)));
    repeat (3) step("won_hold", ev(4, 1, 0, 0, 0, 1, 1, lv(1)));
    start = 1'b1;
    step("won_restart", ev(1, 0, 1, 0, 0, 0, 0, lv(2)));
    start = 1'b0;

`ifdef LEVEL_SEQUENCER_LIVES_EN
    // Losing the last life ends in OVER
    hit = 1'b1;
    step("hit_life2", ev(2, 0, 0, 0, 1, 1, 0, 1));
    hit = 1'b0;
    repeat (29) step("dying_life1", ev(2, 0, 0, 0, 0, 1, 0, 1));
    step("dying_life1_exit", ev(1, 0, 0, 0, 0, 0, 0, 1));
    hit = 1'b1;
    step("hit_last_life", ev(5, 0, 0, 0, 1, 1, 0, 0));
    hit = 1'b0;
    repeat (3) step("over_hold", ev(5, 0, 0, 0, 0, 1, 0, 0));
    start = 1'b1;
    step("over_restart", ev(1, 0, 1, 0, 0, 0, 0, 2));
    start = 1'b0;
`endif

    // Asynchronous reset in the middle of DYING
    hit = 1'b1;
    step("hit_pre_reset", ev(2, 0, 0, 0, 1, 1, 0, lv(1)));
    hit = 1'b0;
    repeat (10) step("dying_pre_reset", ev(2, 0, 0, 0, 0, 1, 0, lv(1)));
    #3;
    Reset_n = 1'b0;
    #1;
    expect_now("async_reset", ev(0, 0, 0, 0, 0, 1, 0, 0));
    @(posedge frame_clk);
    #1;
    expect_now("reset_held_edge", ev(0, 0, 0, 0, 0, 1, 0, 0));
    Reset_n = 1'b1;
    step("post_reset_idle", ev(0, 0, 0, 0, 0, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game-flow controller that sequences the player datapath across start, play, death and level transitions.
- Emits the single-cycle `initialize_level`, `new_level` and `dead` strobes that the player block consumes.
- Emits a `freeze` gate; top level forces the player keycode to 0 while `freeze`=1.
- Tracks current level index and win state. Sits between collision/goal detection and the player block, clocked on the frame clock.

Parameters:
- NUM_LEVELS, 2, number of levels; legal 1..15.
- DEATH_FRAMES, 30, frames spent in DYING; legal 1..255.
- XFER_FRAMES, 60, frames spent in CLEAR before next level; legal 1..255.
- LIVES, 5, starting lives; legal 1..15; used only with LIVES_EN.

Ports:
- frame_clk  in  1  frame clock (one edge per video frame)
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  decoded Enter key, level-sensitive; block edge-detects internally
- hit  in  1  enemy collision this frame
- at_goal  in  1  player inside goal zone
- collected_all  in  1  all coins collected on current level
- initialize_level  out  1  one-cycle strobe: restart game at level 0
- new_level  out  1  one-cycle strobe: advance to next level
- dead  out  1  one-cycle strobe per death
- freeze  out  1  1 = player input gated off
- level  out  4  current level index
- state_out  out  3  FSM state: IDLE=0, PLAY=1, DYING=2, CLEAR=3, WON=4, OVER=5
- game_won  out  1  high while in WON
- lives_left  out  4  remaining lives (LIVES_EN only, else 0)

Behaviour:
- General
  - All outputs are registered.
  - Strobes are high for exactly one frame_clk cycle, coincident with the first cycle of the destination state.
  - `start_q` holds the previous-cycle `start`; a start event is `start & ~start_q`.
- Reset (Reset_n=0, asynchronous, any state, mid-count included)
  - state=IDLE, level=0, counter=0, start_q=0.
  - All strobes=0, freeze=1, game_won=0, lives_left=0.
- IDLE
  - freeze=1.
  - Start event -> PLAY with initialize_level=1; level=0.
- PLAY
  - freeze=0.
  - Priority: hit > (at_goal & collected_all).
  - hit -> DYING, dead=1, counter=0.
  - at_goal & collected_all -> CLEAR, counter=0.
  - at_goal without collected_all: no action.
  - Start events ignored.
- DYING
  - freeze=1; hit ignored.
  - Counter increments each cycle; stays exactly DEATH_FRAMES cycles, then -> PLAY.
  - No further strobe on exit.
- CLEAR
  - freeze=1; stays exactly XFER_FRAMES cycles.
  - On expiry, if level == NUM_LEVELS-1: -> WON, game_won=1.
  - On expiry, otherwise: level <= level+1, new_level=1, -> PLAY.
- WON
  - freeze=1, game_won=1.
  - Start event -> PLAY, level=0, initialize_level=1, game_won=0.
- Counter
  - 8-bit, unsigned, cleared on every state entry.
  - Expiry compare is (counter == N-1); the counter never wraps.
- Level
  - Increments only in CLEAR expiry and never exceeds NUM_LEVELS-1.
  - With NUM_LEVELS=1, CLEAR always exits to WON.
- Simultaneous events
  - hit and goal in the same PLAY cycle: death wins; no CLEAR.
  - start held high continuously produces a single start event.
- Invariant: at most one of initialize_level, new_level, dead is high in any cycle.

Optional Feature:
- Macro: LEVEL_SEQUENCER_LIVES_EN
- Enabled:
  - lives_left loads LIVES whenever initialize_level fires.
  - On each dead strobe, lives_left decrements.
  - If lives_left==1 at the hit, the next state is OVER instead of DYING: dead=1, lives_left=0, freeze=1.
  - OVER: start event -> PLAY, level=0, initialize_level=1, lives_left=LIVES.
- Disabled: lives_left tied to 0; OVER unreachable; a hit always goes to DYING.

Test Plan:
1. Reset_n=0 mid-DYING (counter=10), release -> state_out=0, level=0, freeze=1, all strobes 0, game_won=0.
2. IDLE, start held high 5 cycles -> exactly one initialize_level pulse; state_out=1 on the next cycle; freeze=0.
3. PLAY, hit=1 and at_goal=collected_all=1 same cycle (DEATH_FRAMES=30) -> dead=1 for one cycle; state_out=2 for exactly 30 cycles, then 1; level unchanged; no new_level.
4. NUM_LEVELS=2, XFER_FRAMES=60: goal at level 0 -> CLEAR for 60 cycles, then new_level=1, level=1. Goal again -> after 60 cycles state_out=4, game_won=1, no new_level. Start edge -> level=0, initialize_level=1.
5. PLAY, at_goal=1, collected_all=0 for 100 cycles -> state stays 1, no strobes.
6. LIVES_EN, LIVES=2: two hits (after DYING recovery) -> lives_left 2->1; second hit gives dead=1, state_out=5, lives_left=0. Start edge -> lives_left=2, state_out=1.
